mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// MEM_ARBITER_ROUND_ROBIN_EN (optional) selects round-robin instead of data-first priority.
package mem_arb_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_DEPTH = 50;

  // One-hot grant bit positions shared by the picker and the top.
  localparam int GNT_F_BIT = 0;
  localparam int GNT_D_BIT = 1;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   isRead;
    logic   err;
  } pend_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests; one-hot grant output.
// MEM_ARBITER_ROUND_ROBIN_EN adds the last-winner input and alternates ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  owner_e     i_lastWin,
`endif
  input  logic       i_fReq,
  input  logic       i_dReq,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_fReq && i_dReq) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      // A tie goes to whichever port did not win most recently.
      if (i_lastWin == OWN_FETCH) o_gnt[GNT_D_BIT] = 1'b1;
      else                        o_gnt[GNT_F_BIT] = 1'b1;
`else
      o_gnt[GNT_D_BIT] = 1'b1;
`endif
    end else begin
      o_gnt[GNT_F_BIT] = i_fReq;
      o_gnt[GNT_D_BIT] = i_dReq;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a 1-cycle registered-read memory.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is data-first priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              memwrite,
  output logic              memread,
  input  logic [DATA_W-1:0] out32
);

  logic [1:0]        w_pick;
  logic [1:0]        w_gnt;
  logic              w_fGnt;
  logic              w_dGnt;
  logic              w_any;
  logic [ADDR_W-1:0] w_selAddr;
  logic              w_selRead;
  logic              w_oob;
  logic              w_retValid;
  logic [DATA_W-1:0] w_retData;
  pend_t             r_pend;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  owner_e r_lastWin;

  always_ff @(posedge clk) begin
    if (reset)      r_lastWin <= OWN_FETCH;
    else if (w_any) r_lastWin <= w_dGnt ? OWN_DATA : OWN_FETCH;
  end

  mem_arb_pick u_pick (
    .i_lastWin (r_lastWin),
    .i_fReq    (f_req),
    .i_dReq    (d_req),
    .o_gnt     (w_pick)
  );
`else
  mem_arb_pick u_pick (
    .i_fReq (f_req),
    .i_dReq (d_req),
    .o_gnt  (w_pick)
  );
`endif

  // Requests seen while reset is high are ignored entirely.
  assign w_gnt     = reset ? 2'b00 : w_pick;
  assign w_fGnt    = w_gnt[GNT_F_BIT];
  assign w_dGnt    = w_gnt[GNT_D_BIT];
  assign w_any     = w_fGnt | w_dGnt;
  assign w_selAddr = w_dGnt ? d_addr : f_addr;
  assign w_selRead = w_dGnt ? ~d_we : 1'b1;
  assign w_oob     = 32'(w_selAddr) >= 32'(MEM_DEPTH);

  assign f_gnt = w_fGnt;
  assign d_gnt = w_dGnt;

  always_comb begin
    address   = '0;
    writeData = '0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    if (w_any && !w_oob) begin
      address = w_selAddr;
      memread = w_selRead;
      if (!w_selRead) begin
        memwrite  = 1'b1;
        writeData = d_wdata;
      end
    end
  end

  // One-deep return slot: the memory answers exactly one cycle after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend.valid  <= w_any;
      r_pend.owner  <= w_dGnt ? OWN_DATA : OWN_FETCH;
      r_pend.isRead <= w_selRead;
      r_pend.err    <= w_oob;
    end
  end

  assign w_retValid = r_pend.valid & ~reset;
  assign w_retData  = (w_retValid && r_pend.isRead && !r_pend.err) ? out32 : '0;

  always_comb begin
    f_valid = w_retValid && (r_pend.owner == OWN_FETCH);
    d_valid = w_retValid && (r_pend.owner == OWN_DATA);
    err     = w_retValid && r_pend.err;
    f_rdata = f_valid ? w_retData : '0;
    d_rdata = d_valid ? w_retData : '0;
  end

endmodule
